seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux.sv | 151 +++++++++++++++
 tb/tb_seg_scan_mux.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// -----------------------------------------------------------------------------
// seg_scan_mux
// Multi-digit seven-segment scan multiplexer for board-level debug display.
// One of NUM_CH packed hex channels is snapshotted once per scan frame and its
// nibbles are time-multiplexed onto a shared digit bus feeding an external
// nibble-to-segment decoder. Supports leading-zero blanking and frame-locked
// blinking.
//
// Ports
//   CLK           in   system clock
//   Rst           in   asynchronous active-high reset
//   sel           in   channel select, only takes effect at frame boundaries
//   ch_data       in   packed channels; channel k at [k*DIGITS*4 +: DIGITS*4],
//                      digit 0 (leftmost) is the top nibble of a channel
//   lz_en         in   leading-zero blanking enable
//   blink_en      in   blink enable
//   an            out  digit enables, active-low, one-hot-low when lit
//   display_data  out  nibble for the currently enabled digit
//   blank         out  1 = decoder must drive segments off
//   frame_start   out  one-cycle pulse coincident with digit 0 being presented
// -----------------------------------------------------------------------------
module seg_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2,
    parameter int DIV       = 100000,
    parameter int BLINK_LOG = 6
) (
    input  logic                         CLK,
    input  logic                         Rst,
    input  logic [SEL_W-1:0]             sel,
    input  logic [NUM_CH*DIGITS*4-1:0]   ch_data,
    input  logic                         lz_en,
    input  logic                         blink_en,
    output logic [DIGITS-1:0]            an,
    output logic [3:0]                   display_data,
    output logic                         blank,
    output logic                         frame_start
);

    localparam int DW = DIGITS * 4;
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = BLINK_LOG + 1;

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [DW-1:0]     r_snap;
    logic [BW-1:0]     r_blink;
    logic              r_load_pending;
    logic              r_new_frame;
    logic [DIGITS-1:0] r_an;
    logic [3:0]        r_data;
    logic              r_blank;
    logic              r_frame_start;

    logic              w_tick;
    logic              w_wrap;
    logic              w_load;
    logic              w_dark;
    logic [DW-1:0]     w_chan;
    logic [DIGITS-1:0] w_zero_pre;
    logic [DIGITS-1:0] w_an_dec;
    logic [3:0]        w_nib;
    logic              w_lz_cur;

    assign w_tick = (r_presc == PW'(DIV - 1));
    assign w_wrap = w_tick && (r_idx == IW'(DIGITS - 1));
    assign w_load = w_wrap || r_load_pending;
    assign w_dark = blink_en && r_blink[BW-1];

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        w_chan = ch_data[DW-1:0];
        for (int k = 1; k < NUM_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                w_chan = ch_data[k*DW +: DW];
            end
        end
    end

    // w_zero_pre[i] = nibbles 0..i of the snapshot are all zero.
    always_comb begin
        logic v_run;
        v_run      = 1'b1;
        w_zero_pre = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v_run         = v_run && (r_snap[(DIGITS-1-i)*4 +: 4] == 4'h0);
            w_zero_pre[i] = v_run;
        end
    end

    // The rightmost digit is never LZ-blanked so a zero value still shows "0".
    always_comb begin
        w_nib    = 4'h0;
        w_lz_cur = 1'b0;
        w_an_dec = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_an_dec[i] = 1'b0;
                w_nib       = r_snap[(DIGITS-1-i)*4 +: 4];
                w_lz_cur    = (i != DIGITS - 1) && w_zero_pre[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_presc        <= '0;
            r_idx          <= '0;
            r_snap         <= '0;
            r_blink        <= '0;
            r_load_pending <= 1'b1;
            r_new_frame    <= 1'b0;
            r_an           <= '1;
            r_data         <= 4'h0;
            r_blank        <= 1'b1;
            r_frame_start  <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);

            if (w_tick) begin
                r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
            end

            if (w_load) begin
                r_snap         <= w_chan;
                r_load_pending <= 1'b0;
            end

            if (w_wrap) begin
                r_blink <= r_blink + BW'(1);
            end

            // idx has just become (or stayed, after reset) 0 with a fresh
            // snapshot; unless a coincident tick moved idx on to digit 1.
            r_new_frame <= w_wrap || (r_load_pending && !w_tick);

            r_an          <= w_dark ? '1 : w_an_dec;
            r_data        <= w_nib;
            r_blank       <= w_dark || (lz_en && w_lz_cur);
            r_frame_start <= r_new_frame;
        end
    end

    assign an           = r_an;
    assign display_data = r_data;
    assign blank        = r_blank;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_mux
// Scoreboard bench: the stimulus process pushes expected per-digit records
// tagged with (frame, digit); a monitor samples mid-dwell on the falling edge
// and pops/compares. DUT built with DIGITS=4, NUM_CH=3, DIV=4, BLINK_LOG=1,
// so a frame is 16 cycles and digit d of frame j is sampled 16j+4d+2 cycles
// after reset release.
// -----------------------------------------------------------------------------
module tb_seg_scan_mux;

    logic        CLK = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  sel;
    logic [47:0] ch_data;
    logic        lz_en;
    logic        blink_en;
    logic [3:0]  an;
    logic [3:0]  display_data;
    logic        blank;
    logic        frame_start;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    typedef struct {
        int         frame;
        int         digit;
        logic [3:0] an;
        logic [3:0] dd;
        logic       blank;
        bit         care_dd;
    } exp_t;

    exp_t sb[$];

    seg_scan_mux #(
        .DIGITS(4), .NUM_CH(3), .SEL_W(2), .DIV(4), .BLINK_LOG(1)
    ) u_dut (
        .CLK(CLK), .Rst(Rst), .sel(sel), .ch_data(ch_data),
        .lz_en(lz_en), .blink_en(blink_en), .an(an),
        .display_data(display_data), .blank(blank), .frame_start(frame_start)
    );

    always #5 CLK = ~CLK;

    // Bench cycle count since reset release (edge 1 = first edge after release).
    always @(posedge CLK or posedge Rst) begin
        if (Rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input int j, input logic [15:0] val,
                              input logic [3:0] bpat, input bit dark);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.frame   = j;
            e.digit   = d;
            e.an      = dark ? 4'hF : ~(4'b0001 << d);
            e.dd      = val[(3-d)*4 +: 4];
            e.blank   = dark ? 1'b1 : bpat[3-d];
            e.care_dd = !dark;
            sb.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 1000) begin
            @(negedge CLK);
            guard++;
        end
        if (cyc < k) check("wait_cyc_timeout", cyc, k);
    endtask

    // Monitor
    exp_t m_e;
    int   m_j, m_d, m_pos;
    always @(negedge CLK) begin
        if (!Rst && cyc > 0) begin
            check($sformatf("frame_start@%0d", cyc), frame_start,
                  (cyc == 2) || (cyc > 16 && (cyc % 16) == 1));
            if (cyc >= 2 && ((cyc - 2) % 4) == 0) begin
                m_j   = (cyc - 2) / 16;
                m_d   = ((cyc - 2) / 4) % 4;
                m_pos = m_j * 4 + m_d;
                while (sb.size() > 0 && (sb[0].frame * 4 + sb[0].digit) < m_pos) begin
                    m_e = sb.pop_front();
                    check($sformatf("missed_f%0d_d%0d", m_e.frame, m_e.digit), 1, 0);
                end
                if (sb.size() > 0 && sb[0].frame == m_j && sb[0].digit == m_d) begin
                    m_e = sb.pop_front();
                    check($sformatf("an_f%0d_d%0d", m_j, m_d), an, m_e.an);
                    check($sformatf("blank_f%0d_d%0d", m_j, m_d), blank, m_e.blank);
                    if (m_e.care_dd)
                        check($sformatf("data_f%0d_d%0d", m_j, m_d), display_data, m_e.dd);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1);
    end

    initial begin
        sel      = 2'd0;
        ch_data  = '0;
        ch_data[15:0] = 16'h12AB;
        lz_en    = 1'b0;
        blink_en = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_an", an, 4'hF);
        check("rst_data", display_data, 4'h0);
        check("rst_blank", blank, 1'b1);
        check("rst_fs", frame_start, 1'b0);

        push_frame(0, 16'h12AB, 4'b0000, 0);
        Rst = 1'b0;

        // Mid-frame data change: no tearing, new value next frame.
        wait_cyc(6);
        ch_data[15:0] = 16'h3456;
        push_frame(1, 16'h3456, 4'b0000, 0);

        wait_cyc(20);
        sel = 2'd2;
        ch_data[47:32] = 16'hBEEF;
        push_frame(2, 16'hBEEF, 4'b0000, 0);

        // Mid-frame select change.
        wait_cyc(38);
        sel = 2'd1;
        ch_data[31:16] = 16'h0042;
        push_frame(3, 16'h0042, 4'b0000, 0);

        wait_cyc(63);
        lz_en = 1'b1;
        push_frame(4, 16'h0042, 4'b1100, 0);

        wait_cyc(70);
        ch_data[31:16] = 16'h0000;
        push_frame(5, 16'h0000, 4'b1110, 0);

        wait_cyc(86);
        ch_data[31:16] = 16'h1000;
        push_frame(6, 16'h1000, 4'b0000, 0);

        // Out-of-range select falls back to channel 0.
        wait_cyc(102);
        sel = 2'd3;
        push_frame(7, 16'h3456, 4'b0000, 0);

        // Blink counter value for frame j is j mod 4; dark when it is 2 or 3.
        wait_cyc(127);
        blink_en = 1'b1;
        push_frame(8,  16'h3456, 4'b0000, 0);
        push_frame(9,  16'h3456, 4'b0000, 0);
        push_frame(10, 16'h3456, 4'b0000, 1);
        push_frame(11, 16'h3456, 4'b0000, 1);

        wait_cyc(191);
        blink_en = 1'b0;
        push_frame(12, 16'h3456, 4'b0000, 0);
        push_frame(14, 16'h3456, 4'b0000, 0);

        // Asynchronous reset mid-digit.
        wait_cyc(240);
        #2;
        Rst = 1'b1;
        #1;
        check("async_rst_an", an, 4'hF);
        check("async_rst_blank", blank, 1'b1);
        check("async_rst_data", display_data, 4'h0);
        check("async_rst_fs", frame_start, 1'b0);
        check("sb_drained_epoch1", sb.size(), 0);

        sel      = 2'd0;
        ch_data[15:0] = 16'hCAFE;
        lz_en    = 1'b0;
        blink_en = 1'b0;
        push_frame(0, 16'hCAFE, 4'b0000, 0);
        repeat (2) @(negedge CLK);
        Rst = 1'b0;

        wait_cyc(20);
        check("sb_drained_epoch2", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
